// File: rtl/uart_rx_framer.sv
// 8N1 UART receive framer: synchronizes rx, detects the start edge and
// assembles one byte per frame using ticks from an external baud generator.
module uart_rx_framer (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  input  logic       baud_tick,
  output logic       baud_en,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr
);

  // One-hot so each strobe is a single state flop with no decode glitch.
  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    RECV = 4'b0010,
    DONE = 4'b0100,
    FERR = 4'b1000
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  logic [3:0]  cnt;
  logic [8:0]  shreg;
  logic [3:0]  tick_n;
  logic        fall;

  assign tick_n  = cnt + 4'd1;
  assign fall    = rx_prev & ~rx_sync;

  assign baud_en = state[1];
  assign rcv     = state[2];
  assign ferr    = state[3];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= 4'd0;
      shreg <= 9'd0;
      data  <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (fall) begin
            state <= RECV;
            cnt   <= 4'd0;
            shreg <= 9'd0;
          end
        end
        RECV: begin
          if (baud_tick) begin
            cnt <= tick_n;
            if (tick_n == 4'd1) begin
              if (rx_sync)
                state <= IDLE;
            end else if (tick_n == 4'd10) begin
              // Eight shifts leave data bit 0 at shreg[1].
              if (rx_sync) begin
                data  <= shreg[8:1];
                state <= DONE;
              end else begin
                state <= FERR;
              end
            end else begin
              shreg <= {rx_sync, shreg[8:1]};
            end
          end
        end
        DONE:    state <= IDLE;
        FERR:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer with a mid-bit baud tick model
// (16 clk per bit) and a strobe monitor.
module tb_uart_rx_framer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       baud_tick = 1'b0;
  logic       baud_en;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;

  int errs = 0;
  int checks = 0;

  bit spur = 1'b0;
  int bc = 0;
  int sc = 0;

  int tk = 0;
  bit pend = 1'b0;
  bit lat_valid = 1'b0;
  logic lat_rcv, lat_ferr, lat_en;
  int rcv_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int en_cnt = 0;
  logic [7:0] got_q[$];

  uart_rx_framer dut (
    .clk(clk),
    .rstn(rstn),
    .rx(rx),
    .baud_tick(baud_tick),
    .baud_en(baud_en),
    .data(data),
    .rcv(rcv),
    .ferr(ferr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Baud generator model: first tick 8 cycles into RECV, then every 16.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (spur) begin
        baud_tick = (sc % 5 == 0);
        sc++;
      end else if (!baud_en) begin
        bc = 0;
        baud_tick = 1'b0;
      end else begin
        baud_tick = (bc == 7);
        bc = (bc == 15) ? 0 : bc + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        lat_rcv   = rcv;
        lat_ferr  = ferr;
        lat_en    = baud_en;
        lat_valid = 1'b1;
        pend      = 1'b0;
      end
      if (!baud_en) tk = 0;
      else if (baud_tick) begin
        tk++;
        if (tk == 10) pend = 1'b1;
      end
      if (rcv) begin
        rcv_cnt++;
        got_q.push_back(data);
      end
      if (ferr) ferr_cnt++;
      if (rcv && ferr) both_cnt++;
      if (baud_en) en_cnt++;
    end
  end

  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic clr;
    rcv_cnt = 0;
    ferr_cnt = 0;
    en_cnt = 0;
    lat_valid = 1'b0;
    got_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(1);
    chk("rst_baud_en", baud_en, 1'b0);
    chk("rst_rcv", rcv, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_data", data, 8'h00);

    clr();
    spur = 1'b1;
    idle(40);
    spur = 1'b0;
    idle(2);
    chk("spur_en_cnt", en_cnt, 0);
    chk("spur_rcv", rcv_cnt, 0);

    clr();
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    chk("false_rcv", rcv_cnt, 0);
    chk("false_ferr", ferr_cnt, 0);
    chk("false_data", data, 8'h00);
    chk("false_en", baud_en, 1'b0);

    clr();
    send(8'h55, 1'b1);
    idle(4);
    chk("b55_data", data, 8'h55);
    chk("b55_rcv_cnt", rcv_cnt, 1);
    chk("b55_ferr_cnt", ferr_cnt, 0);
    chk("b55_lat_valid", lat_valid, 1'b1);
    chk("b55_lat_rcv", lat_rcv, 1'b1);
    chk("b55_lat_en", lat_en, 1'b0);
    chk("b55_en_after", baud_en, 1'b0);

    clr();
    send(8'hA3, 1'b1);
    send(8'h0F, 1'b1);
    idle(4);
    chk("b2b_rcv_cnt", rcv_cnt, 2);
    chk("b2b_first", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'hA3);
    chk("b2b_second", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'h0F);
    chk("b2b_data", data, 8'h0F);

    clr();
    send(8'h3C, 1'b0);
    chk("fe_ferr_cnt", ferr_cnt, 1);
    chk("fe_rcv_cnt", rcv_cnt, 0);
    chk("fe_lat_ferr", lat_ferr, 1'b1);
    chk("fe_lat_rcv", lat_rcv, 1'b0);
    chk("fe_data", data, 8'h0F);
    en_cnt = 0;
    idle(50);
    chk("brk_en_cnt", en_cnt, 0);
    rx = 1'b1;
    idle(5);
    clr();
    send(8'h5A, 1'b1);
    idle(4);
    chk("brk_after_data", data, 8'h5A);
    chk("brk_after_rcv", rcv_cnt, 1);

    clr();
    fork
      send(8'hFF, 1'b1);
      begin
        w = 0;
        while (tk < 5 && w < 200) begin
          @(negedge clk);
          w++;
        end
        chk("mid_tick5_seen", (tk >= 5), 1'b1);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("mid_rst_en", baud_en, 1'b0);
        chk("mid_rst_rcv", rcv, 1'b0);
        chk("mid_rst_ferr", ferr, 1'b0);
        chk("mid_rst_data", data, 8'h00);
      end
    join
    idle(4);
    chk("mid_no_rcv", rcv_cnt, 0);
    chk("mid_no_ferr", ferr_cnt, 0);
    clr();
    send(8'h81, 1'b1);
    idle(4);
    chk("post_rst_data", data, 8'h81);
    chk("post_rst_rcv", rcv_cnt, 1);

    chk("never_both", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
